// File: rtl/htu_memq.sv
// htu_memq - writeback/refill request queue for the hash/tag-update pipe.
//
// Buffers writeback (aw) and refill (ar) line requests in two FIFOs and
// arbitrates them round-robin onto one registered command port. A refill is
// held back while any queued writeback targets the same cache line, so a
// refill never overtakes a pending writeback of its line.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   u_aw{valid,ready,id,addr}      writeback request in
//   u_ar{valid,ready,id,addr}      refill request in
//   d_cmd_{valid,ready,write,id,addr}  registered command out (write=1: writeback)
//   aw_count, ar_count             FIFO occupancies
//
// Optional build macro HTU_MEMQ_PERF_EN adds saturating 32-bit counters:
//   perf_hazard_stall  cycles the ar head is blocked by a same-line writeback
//   perf_bp_stall      cycles d_cmd_valid && !d_cmd_ready
//   perf_cmd_cnt       accepted commands
module htu_memq #(
  parameter int AW_DEPTH  = 4,
  parameter int AR_DEPTH  = 4,
  parameter int ID_W      = 8,
  parameter int LINE_LOG2 = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      u_awvalid,
  output logic                      u_awready,
  input  logic [ID_W-1:0]           u_awid,
  input  logic [31:0]               u_awaddr,
  input  logic                      u_arvalid,
  output logic                      u_arready,
  input  logic [ID_W-1:0]           u_arid,
  input  logic [31:0]               u_araddr,
  output logic                      d_cmd_valid,
  input  logic                      d_cmd_ready,
  output logic                      d_cmd_write,
  output logic [ID_W-1:0]           d_cmd_id,
  output logic [31:0]               d_cmd_addr,
  output logic [$clog2(AW_DEPTH):0] aw_count,
  output logic [$clog2(AR_DEPTH):0] ar_count
`ifdef HTU_MEMQ_PERF_EN
  ,
  output logic [31:0]               perf_hazard_stall,
  output logic [31:0]               perf_bp_stall,
  output logic [31:0]               perf_cmd_cnt
`endif
);

  localparam int AWP = $clog2(AW_DEPTH);
  localparam int ARP = $clog2(AR_DEPTH);
  localparam logic [AWP:0] AW_FULL = (AWP+1)'(AW_DEPTH);
  localparam logic [ARP:0] AR_FULL = (ARP+1)'(AR_DEPTH);

  logic [ID_W-1:0]     aw_id_q   [AW_DEPTH];
  logic [31:0]         aw_addr_q [AW_DEPTH];
  logic [AW_DEPTH-1:0] aw_vld;
  logic [AWP-1:0]      aw_wptr, aw_rptr;

  logic [ID_W-1:0]     ar_id_q   [AR_DEPTH];
  logic [31:0]         ar_addr_q [AR_DEPTH];
  logic [ARP-1:0]      ar_wptr, ar_rptr;

  logic last_ar;    // 0 = last grant went to aw, 1 = to ar
  logic aw_enq, ar_enq, aw_deq, ar_deq;
  logic aw_elig, ar_elig, ar_hazard, cmd_load, grant_ar;

  // Ready depends only on registered occupancy: a full FIFO stays blocked
  // for the cycle even if its head leaves at the same edge.
  assign u_awready = (aw_count != AW_FULL);
  assign u_arready = (ar_count != AR_FULL);
  assign aw_enq    = u_awvalid && u_awready;
  assign ar_enq    = u_arvalid && u_arready;

  // Same-line check of the ar head against every live aw entry. Entries
  // written this cycle are not yet valid, so an older ar may still win.
  always_comb begin
    ar_hazard = 1'b0;
    for (int i = 0; i < AW_DEPTH; i++) begin
      if (aw_vld[i] &&
          (aw_addr_q[i][31:LINE_LOG2] == ar_addr_q[ar_rptr][31:LINE_LOG2]))
        ar_hazard = 1'b1;
    end
  end

  assign aw_elig  = (aw_count != '0);
  assign ar_elig  = (ar_count != '0) && !ar_hazard;
  assign cmd_load = (!d_cmd_valid || d_cmd_ready) && (aw_elig || ar_elig);
  // With both sides eligible, take the one opposite the last grant.
  assign grant_ar = ar_elig && (!aw_elig || !last_ar);
  assign aw_deq   = cmd_load && !grant_ar;
  assign ar_deq   = cmd_load && grant_ar;

  // Payload storage needs no reset; liveness is tracked by aw_vld/counts.
  always_ff @(posedge clk) begin
    if (aw_enq) begin
      aw_id_q[aw_wptr]   <= u_awid;
      aw_addr_q[aw_wptr] <= u_awaddr;
    end
    if (ar_enq) begin
      ar_id_q[ar_wptr]   <= u_arid;
      ar_addr_q[ar_wptr] <= u_araddr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_wptr  <= '0;
      aw_rptr  <= '0;
      aw_vld   <= '0;
      aw_count <= '0;
      ar_wptr  <= '0;
      ar_rptr  <= '0;
      ar_count <= '0;
    end else begin
      if (aw_deq) begin
        aw_rptr         <= aw_rptr + AWP'(1);
        aw_vld[aw_rptr] <= 1'b0;
      end
      if (aw_enq) begin
        aw_wptr         <= aw_wptr + AWP'(1);
        aw_vld[aw_wptr] <= 1'b1;
      end
      if (ar_deq) ar_rptr <= ar_rptr + ARP'(1);
      if (ar_enq) ar_wptr <= ar_wptr + ARP'(1);
      aw_count <= aw_count + {{AWP{1'b0}}, aw_enq} - {{AWP{1'b0}}, aw_deq};
      ar_count <= ar_count + {{ARP{1'b0}}, ar_enq} - {{ARP{1'b0}}, ar_deq};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_cmd_valid <= 1'b0;
      d_cmd_write <= 1'b0;
      d_cmd_id    <= '0;
      d_cmd_addr  <= '0;
      last_ar     <= 1'b0;
    end else if (cmd_load) begin
      d_cmd_valid <= 1'b1;
      d_cmd_write <= !grant_ar;
      d_cmd_id    <= grant_ar ? ar_id_q[ar_rptr]   : aw_id_q[aw_rptr];
      d_cmd_addr  <= grant_ar ? ar_addr_q[ar_rptr] : aw_addr_q[aw_rptr];
      last_ar     <= grant_ar;
    end else if (d_cmd_ready) begin
      d_cmd_valid <= 1'b0;
    end
  end

`ifdef HTU_MEMQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_hazard_stall <= '0;
      perf_bp_stall     <= '0;
      perf_cmd_cnt      <= '0;
    end else begin
      if ((ar_count != '0) && ar_hazard && (perf_hazard_stall != '1))
        perf_hazard_stall <= perf_hazard_stall + 32'd1;
      if (d_cmd_valid && !d_cmd_ready && (perf_bp_stall != '1))
        perf_bp_stall <= perf_bp_stall + 32'd1;
      if (d_cmd_valid && d_cmd_ready && (perf_cmd_cnt != '1))
        perf_cmd_cnt <= perf_cmd_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_htu_memq.sv
// Bench for htu_memq: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations on the issue order.
module tb_htu_memq;
  localparam int AWD = 4;
  localparam int ARD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        u_awvalid, u_arvalid, u_awready, u_arready;
  logic [7:0]  u_awid, u_arid;
  logic [31:0] u_awaddr, u_araddr;
  logic        d_cmd_valid, d_cmd_ready, d_cmd_write;
  logic [7:0]  d_cmd_id;
  logic [31:0] d_cmd_addr;
  logic [2:0]  aw_count, ar_count;
`ifdef HTU_MEMQ_PERF_EN
  logic [31:0] perf_hazard_stall, perf_bp_stall, perf_cmd_cnt;
`endif

  always #5 clk = ~clk;

  htu_memq #(.AW_DEPTH(AWD), .AR_DEPTH(ARD), .ID_W(8), .LINE_LOG2(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .u_awvalid(u_awvalid), .u_awready(u_awready), .u_awid(u_awid), .u_awaddr(u_awaddr),
    .u_arvalid(u_arvalid), .u_arready(u_arready), .u_arid(u_arid), .u_araddr(u_araddr),
    .d_cmd_valid(d_cmd_valid), .d_cmd_ready(d_cmd_ready), .d_cmd_write(d_cmd_write),
    .d_cmd_id(d_cmd_id), .d_cmd_addr(d_cmd_addr),
    .aw_count(aw_count), .ar_count(ar_count)
`ifdef HTU_MEMQ_PERF_EN
    , .perf_hazard_stall(perf_hazard_stall), .perf_bp_stall(perf_bp_stall),
    .perf_cmd_cnt(perf_cmd_cnt)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {logic [7:0] id; logic [31:0] addr;} req_t;
  typedef struct packed {logic w; logic [7:0] id; logic [31:0] addr;} cmd_t;

  req_t        maw[$], mar[$];
  cmd_t        mlog[$];        // commands accepted by the memory side
  bit          m_last, m_valid, m_write;
  logic [7:0]  m_id;
  logic [31:0] m_addr;
  bit          m_aw_rdy, m_ar_rdy, m_aw_el, m_ar_el, m_haz, m_pick_ar;
  req_t        m_r;
  longint      m_haz_cnt, m_bp_cnt, m_cmd_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      maw.delete(); mar.delete();
      m_last = 0; m_valid = 0; m_write = 0; m_id = '0; m_addr = '0;
      m_haz_cnt = 0; m_bp_cnt = 0; m_cmd_cnt = 0;
    end else begin
      m_aw_rdy = maw.size() < AWD;
      m_ar_rdy = mar.size() < ARD;
      m_haz = 0;
      if (mar.size() > 0)
        foreach (maw[i]) if (maw[i].addr[31:6] == mar[0].addr[31:6]) m_haz = 1;
      m_aw_el = maw.size() > 0;
      m_ar_el = (mar.size() > 0) && !m_haz;
      if (mar.size() > 0 && m_haz) m_haz_cnt++;
      if (m_valid && !d_cmd_ready) m_bp_cnt++;
      if (m_valid && d_cmd_ready) begin
        m_cmd_cnt++;
        mlog.push_back({m_write, m_id, m_addr});
      end
      if ((!m_valid || d_cmd_ready) && (m_aw_el || m_ar_el)) begin
        // round robin: both eligible -> the side not granted last time
        m_pick_ar = m_ar_el && !(m_aw_el && m_last);
        if (m_pick_ar) m_r = mar.pop_front(); else m_r = maw.pop_front();
        m_valid = 1; m_write = !m_pick_ar; m_id = m_r.id; m_addr = m_r.addr;
        m_last = m_pick_ar;
      end else if (d_cmd_ready) begin
        m_valid = 0;
      end
      if (u_awvalid && m_aw_rdy) maw.push_back({u_awid, u_awaddr});
      if (u_arvalid && m_ar_rdy) mar.push_back({u_arid, u_araddr});
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("awready", u_awready, maw.size() < AWD);
      check("arready", u_arready, mar.size() < ARD);
      check("aw_count", aw_count, maw.size());
      check("ar_count", ar_count, mar.size());
      check("cmd_valid", d_cmd_valid, m_valid);
      if (m_valid) begin
        check("cmd_write", d_cmd_write, m_write);
        check("cmd_id", d_cmd_id, m_id);
        check("cmd_addr", d_cmd_addr, m_addr);
      end
`ifdef HTU_MEMQ_PERF_EN
      check("perf_hazard", perf_hazard_stall, m_haz_cnt);
      check("perf_bp", perf_bp_stall, m_bp_cnt);
      check("perf_cmd", perf_cmd_cnt, m_cmd_cnt);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(negedge clk); #1;
  endtask

  task automatic send(bit a, logic [7:0] ida, logic [31:0] ada,
                      bit r, logic [7:0] idr, logic [31:0] adr);
    int n = 0;
    bit pa = a, pr = r, acc_a, acc_r;
    u_awid = ida; u_awaddr = ada; u_arid = idr; u_araddr = adr;
    u_awvalid = pa; u_arvalid = pr;
    while ((pa || pr) && n < 50) begin
      acc_a = pa && u_awready;
      acc_r = pr && u_arready;
      cyc(); n++;
      if (acc_a) pa = 0;
      if (acc_r) pr = 0;
      u_awvalid = pa; u_arvalid = pr;
    end
    u_awvalid = 0; u_arvalid = 0;
    check("send_timeout", n < 50, 1);
  endtask

  task automatic drain();
    int n = 0;
    d_cmd_ready = 1;
    while ((maw.size() > 0 || mar.size() > 0 || m_valid) && n < 200) begin
      cyc(); n++;
    end
    check("drain_timeout", n < 200, 1);
  endtask

  task automatic chk_log(string nm, int idx, bit w, logic [7:0] id, logic [31:0] addr);
    if (idx < mlog.size()) begin
      check({nm, "_w"}, mlog[idx].w, w);
      check({nm, "_id"}, mlog[idx].id, id);
      check({nm, "_addr"}, mlog[idx].addr, addr);
    end else begin
      check({nm, "_missing"}, mlog.size(), idx + 1);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 0; cyc(); cyc(); rst_n = 1; cyc();
  endtask

  int  enq_total;
  int  id_ctr;
  bit  aw_acc, ar_acc;
  logic [7:0] exp_ids [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    u_awvalid = 0; u_arvalid = 0; u_awid = 0; u_arid = 0;
    u_awaddr = 0; u_araddr = 0; d_cmd_ready = 0;
    rst_n = 0;
    cyc(); cyc();
    // reset state
    check("rst_cmd_valid", d_cmd_valid, 0);
    check("rst_cmd_write", d_cmd_write, 0);
    check("rst_cmd_id", d_cmd_id, 0);
    check("rst_cmd_addr", d_cmd_addr, 0);
    check("rst_awready", u_awready, 1);
    check("rst_arready", u_arready, 1);
    check("rst_aw_count", aw_count, 0);
    check("rst_ar_count", ar_count, 0);
    rst_n = 1;
    chk_en = 1;
    cyc();

    // single writeback: one cycle after enqueue it is on the command port
    d_cmd_ready = 1;
    send(1, 8'd3, 32'h1000, 0, 8'd0, 32'h0);
    check("single_pre_valid", d_cmd_valid, 0);
    cyc();
    check("single_valid", d_cmd_valid, 1);
    check("single_write", d_cmd_write, 1);
    check("single_id", d_cmd_id, 3);
    check("single_addr", d_cmd_addr, 32'h1000);
    check("single_aw_count", aw_count, 0);
    drain();

    // same-line hazard: refill waits for the writeback to leave the FIFO
    d_cmd_ready = 0;
    send(1, 8'h01, 32'h9000, 0, 8'h0, 32'h0);
    send(1, 8'h02, 32'h2000, 0, 8'h0, 32'h0);
    send(0, 8'h0, 32'h0, 1, 8'h03, 32'h2010);
    cyc(); cyc(); cyc();
    check("haz_ar_count", ar_count, 1);
    check("haz_aw_count", aw_count, 1);
    check("haz_cmd_id", d_cmd_id, 8'h01);
`ifdef HTU_MEMQ_PERF_EN
    check("haz_perf_nonzero", perf_hazard_stall > 0, 1);
`endif
    mlog.delete();
    drain();
    check("haz_log_size", mlog.size(), 3);
    chk_log("haz0", 0, 1, 8'h01, 32'h9000);
    chk_log("haz1", 1, 1, 8'h02, 32'h2000);
    chk_log("haz2", 2, 0, 8'h03, 32'h2010);

    // round robin from reset: last grant is aw, so ar goes first
    pulse_reset();
    d_cmd_ready = 1;
    mlog.delete();
    for (int i = 0; i < 4; i++)
      send(1, 8'h10 + 8'(i), 32'h3000 + 32'(i * 64),
           1, 8'h20 + 8'(i), 32'h8000 + 32'(i * 64));
    drain();
    exp_ids = '{8'h20, 8'h10, 8'h21, 8'h11, 8'h22, 8'h12, 8'h23, 8'h13};
    check("rr_log_size", mlog.size(), 8);
    for (int i = 0; i < 8; i++)
      chk_log("rr", i, exp_ids[i][4], exp_ids[i],
              exp_ids[i][4] ? 32'h3000 + 32'((exp_ids[i] & 8'h0f) * 64)
                            : 32'h8000 + 32'((exp_ids[i] & 8'h0f) * 64));

    // full FIFO: first aw moves into the command register, four fill the FIFO
    d_cmd_ready = 0;
    mlog.delete();
    for (int i = 0; i < 5; i++)
      send(1, 8'h40 + 8'(i), 32'h5000 + 32'(i * 64), 0, 8'h0, 32'h0);
    check("full_awready", u_awready, 0);
    check("full_aw_count", aw_count, 4);
    u_awvalid = 1; u_awid = 8'h45; u_awaddr = 32'h5140;
    cyc(); cyc();
    check("full_held_count", aw_count, 4);
    check("full_held_cmd", d_cmd_id, 8'h40);
    d_cmd_ready = 1;
    send(1, 8'h45, 32'h5140, 0, 8'h0, 32'h0);
    drain();
    check("full_log_size", mlog.size(), 6);
    for (int i = 0; i < 6; i++)
      chk_log("full", i, 1, 8'h40 + 8'(i), 32'h5000 + 32'(i * 64));

    // random backpressure with clustered lines to exercise hazards
    mlog.delete();
    enq_total = 0;
    id_ctr = 8'h80;
    for (int n = 0; n < 120; n++) begin
      if (!u_awvalid && $urandom_range(0, 2) != 0) begin
        u_awvalid = 1; u_awid = 8'(id_ctr); id_ctr++;
        u_awaddr = 32'h6000 + 32'($urandom_range(0, 3) * 64) + 32'($urandom_range(0, 63));
      end
      if (!u_arvalid && $urandom_range(0, 2) != 0) begin
        u_arvalid = 1; u_arid = 8'(id_ctr); id_ctr++;
        u_araddr = 32'h6000 + 32'($urandom_range(0, 3) * 64) + 32'($urandom_range(0, 63));
      end
      d_cmd_ready = 1'($urandom_range(0, 1));
      aw_acc = u_awvalid && u_awready;
      ar_acc = u_arvalid && u_arready;
      cyc();
      if (aw_acc) begin u_awvalid = 0; enq_total++; end
      if (ar_acc) begin u_arvalid = 0; enq_total++; end
    end
    u_awvalid = 0; u_arvalid = 0;
    drain();
    check("rand_no_loss", mlog.size(), enq_total);

    // async reset mid-stream with three requests outstanding
    d_cmd_ready = 0;
    send(1, 8'h70, 32'hA000, 1, 8'h72, 32'hB000);
    send(1, 8'h71, 32'hA040, 0, 8'h0, 32'h0);
    check("ar_pre_valid", d_cmd_valid, 1);
    #2;
    rst_n = 0;
    #1;
    check("arst_cmd_valid", d_cmd_valid, 0);
    check("arst_aw_count", aw_count, 0);
    check("arst_ar_count", ar_count, 0);
    cyc();
    rst_n = 1;
    cyc();
    mlog.delete();
    d_cmd_ready = 1;
    send(0, 8'h0, 32'h0, 1, 8'h55, 32'h4000);
    drain();
    check("arst_log_size", mlog.size(), 1);
    chk_log("arst", 0, 0, 8'h55, 32'h4000);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
